regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port among NREQ writeback requesters with round-robin arbitration.
//  Also runs a sequenced clear that writes zero to x1..x31 on command.
//  Sits between the writeback sources (ALU, LSU, CSR/debug) and regfile's rd_addr_i/rd_data_i/rd_wren_i.
//  All outputs to regfile are registered.
// PARAMETERS
//  NREQ    default 3   number of write requesters (2..8)
//  STAT_W  default 16  width of each optional grant counter
// PORTS
//  clk_i           in   1          clock
//  rst_i           in   1          reset, synchronous, active-high
//  req_valid_i     in   NREQ       requester k has a write pending
//  req_addr_i      in   NREQ*5     dest reg of requester k, bits [5k+4:5k]
//  req_data_i      in   NREQ*32    write data of requester k, bits [32k+31:32k]
//  req_ready_o     out  NREQ       one-hot grant; a write is accepted when valid&ready
//  clear_i         in   1          one-cycle pulse: start register clear sequence
//  clear_busy_o    out  1          high while the clear sequence runs
//  rd_addr_o       out  5          to regfile rd_addr_i
//  rd_data_o       out  32         to regfile rd_data_i
//  rd_wren_o       out  1          to regfile rd_wren_i
//  grant_cnt_o     out  NREQ*STAT_W  accepted-write count per requester (REGFILE_ARB_STAT_EN only)
// BEHAVIOUR
//  Reset: req_ready_o=0, rd_addr_o=0, rd_data_o=0, rd_wren_o=0, clear_busy_o=0; FSM=IDLE; rr_ptr=0.
//  FSM states: IDLE, CLEAR.
//  - IDLE -> CLEAR when clear_i=1.
//    - clr_idx loads 1.
//    - Any write accepted in that same cycle still issues.
//  - CLEAR: one write per cycle, rd_addr_o=clr_idx, rd_data_o=0, rd_wren_o=1.
//    - clr_idx increments 1..31; returns to IDLE after issuing index 31.
//    - Sequence lasts 31 cycles.
//    - clear_i is ignored while in CLEAR.
//  clear_busy_o is registered.
//    - High from the cycle after clear_i through the cycle the write to x31 is presented.
//  Arbitration (IDLE only; combinational on req_valid_i and rr_ptr):
//    - Grant the first valid requester searching rr_ptr, rr_ptr+1, ... mod NREQ.
//    - On an accept, rr_ptr <= granted+1 mod NREQ; otherwise rr_ptr holds.
//    - At most one ready bit is high.
//    - ready is never high for a non-valid requester.
//    - All ready bits are 0 in CLEAR and during the clear_i cycle.
//  Latency: an accept in cycle N presents rd_addr_o/rd_data_o/rd_wren_o=1 in cycle N+1.
//    - Throughput is one write per cycle.
//  No accept in a cycle: rd_wren_o=0 next cycle; rd_addr_o/rd_data_o hold their last values.
//  Writes to x0: accepted normally, rd_wren_o held 0, rr_ptr still advances.
//    - Counted by grant_cnt_o.
//  Requesters must hold valid/addr/data stable until accepted.
//  Reset asserted mid-CLEAR: abort immediately, everything returns to reset values.
//    - The partial clear is not resumed.
//  clear_i coincident with rst_i: reset wins.
// CONFIGURATION
//  REGFILE_ARB_STAT_EN defined:
//    - grant_cnt_o is present; per-requester counters increment on each accept.
//    - Counters saturate at all-ones and reset to 0.
//    - CLEAR writes are not counted.
//  REGFILE_ARB_STAT_EN undefined:
//    - grant_cnt_o port and the counters are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  regfile_pkg:
//    - localparams REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
//    - typedef enum logic {ARB_IDLE, ARB_CLEAR} arb_state_e.
//    - typedef logic [REG_ADDR_W-1:0] reg_addr_t.
//  Sub-module rr_arbiter (param N): inputs req, ptr, en; outputs one-hot gnt and gnt_idx.
//    - Purely combinational.
//  Top level holds rr_ptr, FSM, clr_idx, output register stage and optional counters.
// TESTING
//  1. Reset: hold rst_i 2 cycles with all req_valid_i=1 -> req_ready_o=0, rd_wren_o=0, clear_busy_o=0.
//  2. Single request: req0 x5=0xDEADBEEF, others idle -> ready0 in cycle N.
//     - Cycle N+1: rd_addr_o=5, rd_data_o=0xDEADBEEF, rd_wren_o=1.
//  3. Fairness: NREQ=3, all valid continuously for 6 cycles with rr_ptr=0 -> grants 0,1,2,0,1,2.
//     - Exactly one ready per cycle.
//  4. x0 write: req1 x0=0x1234 -> accepted; rd_wren_o stays 0.
//     - rr_ptr advances to 2; grant_cnt_o[1] increments when the STAT build is enabled.
//  5. Clear: pulse clear_i while req2 is valid -> req_ready_o=0 for 32 cycles.
//     - rd_addr_o steps 1..31 with rd_data_o=0, rd_wren_o=1.
//     - After that, req2 is granted.
//  6. Reset mid-clear: assert rst_i when rd_addr_o=10 -> next cycle clear_busy_o=0, rd_wren_o=0, FSM=IDLE.
//  Assertions: $onehot0(req_ready_o); ready&~valid never; no ready while clear_busy_o.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and constants for the register-file write arbiter.
//   Contents:
//     REG_ADDR_W, XLEN, NUM_REGS  register-file geometry
//     arb_state_e                 arbiter FSM states
//     reg_addr_t                  register index type
//     CLR_FIRST / CLR_LAST        first and last index written by the clear
//                                 sequence (x0 is hard-wired, so it is skipped)
//     wrap_inc()                  modulo increment for the round-robin pointer
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_CLEAR
    } arb_state_e;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t CLR_FIRST = reg_addr_t'(1);
    localparam reg_addr_t CLR_LAST  = reg_addr_t'(NUM_REGS - 1);

    // Increment idx and wrap to 0 once it reaches n-1.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Searches req starting at ptr,
//   then ptr+1, ... modulo N, and grants the first set bit.
//   Ports:
//     req      in   N    request vector
//     ptr      in   IW   index with highest priority this cycle
//     en       in   1    when low, no grant is issued
//     gnt      out  N    one-hot (or zero) grant
//     gnt_idx  out  IW   index of the granted bit (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic        w_found;
    int unsigned w_pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 0; i < N; i++) begin
            // Candidate position i steps after the pointer, wrapped into 0..N-1.
            w_pos = int'(ptr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (en && !w_found && req[w_pos]) begin
                gnt[w_pos] = 1'b1;
                gnt_idx    = IW'(w_pos);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//   Shares the single register-file write port among NREQ writeback sources
//   with round-robin arbitration, and runs a sequenced clear of x1..x31.
//   Every output towards the register file is registered.
//
//   Optional feature macro: REGFILE_ARB_STAT_EN
//     defined   -> grant_cnt_o port and saturating per-requester accept counters
//     undefined -> port and counters absent, behaviour otherwise identical
//
//   Ports:
//     clk_i         in   1             clock
//     rst_i         in   1             synchronous active-high reset
//     req_valid_i   in   NREQ          requester k has a write pending
//     req_addr_i    in   NREQ*5        dest reg of requester k, [5k+4:5k]
//     req_data_i    in   NREQ*32       write data of requester k, [32k+31:32k]
//     req_ready_o   out  NREQ          one-hot grant (accept = valid & ready)
//     clear_i       in   1             pulse: start the clear sequence
//     clear_busy_o  out  1             high while the clear sequence runs
//     rd_addr_o     out  5             register-file write address
//     rd_data_o     out  32            register-file write data
//     rd_wren_o     out  1             register-file write enable
//     grant_cnt_o   out  NREQ*STAT_W   accepted writes per requester (STAT only)
//
//   FSM states:
//     state     | meaning
//     ----------+--------------------------------------------------------
//     ARB_IDLE  | arbitrating requesters, one accepted write per cycle
//     ARB_CLEAR | writing zero to clr_idx each cycle, requesters stalled
// -----------------------------------------------------------------------------
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int STAT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NREQ-1:0]            req_valid_i,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*XLEN-1:0]       req_data_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic                       clear_i,
    output logic                       clear_busy_o,
    output logic [REG_ADDR_W-1:0]      rd_addr_o,
    output logic [XLEN-1:0]            rd_data_o,
    output logic                       rd_wren_o
`ifdef REGFILE_ARB_STAT_EN
    ,
    output logic [NREQ*STAT_W-1:0]     grant_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_e       r_state;
    reg_addr_t        r_clr_idx;
    logic [IDX_W-1:0] r_rr_ptr;
    reg_addr_t        r_rd_addr;
    logic [XLEN-1:0]  r_rd_data;
    logic             r_rd_wren;
    logic             r_clear_busy;

    logic             w_arb_en;
    logic [NREQ-1:0]  w_gnt;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_accept;
    logic [IDX_W-1:0] w_ptr_next;
    reg_addr_t        w_sel_addr;
    logic [XLEN-1:0]  w_sel_data;

    // No grants while in reset, while clearing, or in the cycle clear_i is
    // seen: the write port is about to belong to the clear sequence.
    assign w_arb_en = !rst_i && (r_state == ARB_IDLE) && !clear_i;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid_i),
        .ptr     (r_rr_ptr),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // The arbiter only grants valid requesters, so any grant is an accept.
    assign w_accept    = |w_gnt;
    assign req_ready_o = w_gnt;
    assign w_ptr_next  = IDX_W'(wrap_inc(int'(w_gnt_idx), NREQ));

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt[k]) begin
                w_sel_addr = req_addr_i[k*REG_ADDR_W +: REG_ADDR_W];
                w_sel_data = req_data_i[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ARB_IDLE;
            r_clr_idx    <= '0;
            r_rr_ptr     <= '0;
            r_rd_addr    <= '0;
            r_rd_data    <= '0;
            r_rd_wren    <= 1'b0;
            r_clear_busy <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_rr_ptr  <= w_ptr_next;
                        r_rd_addr <= w_sel_addr;
                        r_rd_data <= w_sel_data;
                        // x0 is read-only: the write is consumed but not issued.
                        r_rd_wren <= (w_sel_addr != '0);
                    end else begin
                        r_rd_wren <= 1'b0;
                    end
                    if (clear_i) begin
                        // First clear write is presented in the very next cycle.
                        r_state      <= ARB_CLEAR;
                        r_clr_idx    <= CLR_FIRST;
                        r_rd_addr    <= CLR_FIRST;
                        r_rd_data    <= '0;
                        r_rd_wren    <= 1'b1;
                        r_clear_busy <= 1'b1;
                    end
                end
                ARB_CLEAR: begin
                    // r_clr_idx is the index currently on rd_addr_o.
                    if (r_clr_idx == CLR_LAST) begin
                        r_state      <= ARB_IDLE;
                        r_rd_wren    <= 1'b0;
                        r_clear_busy <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + reg_addr_t'(1);
                        r_rd_addr <= r_clr_idx + reg_addr_t'(1);
                        r_rd_data <= '0;
                        r_rd_wren <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign rd_addr_o    = r_rd_addr;
    assign rd_data_o    = r_rd_data;
    assign rd_wren_o    = r_rd_wren;
    assign clear_busy_o = r_clear_busy;

`ifdef REGFILE_ARB_STAT_EN
    logic [STAT_W-1:0] r_grant_cnt [NREQ];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREQ; k++) begin
                r_grant_cnt[k] <= '0;
            end
        end else begin
            // Grants only happen in IDLE, so clear writes never count.
            for (int k = 0; k < NREQ; k++) begin
                if (w_gnt[k] && !(&r_grant_cnt[k])) begin
                    r_grant_cnt[k] <= r_grant_cnt[k] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
        assign grant_cnt_o[g*STAT_W +: STAT_W] = r_grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//   Directed bench for regfile_wr_arbiter (NREQ=3, STAT_W=16). Honors
//   REGFILE_ARB_STAT_EN to connect and check grant_cnt_o.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        clear_i;
    logic        clear_busy;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wren;
`ifdef REGFILE_ARB_STAT_EN
    logic [47:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic found;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.NREQ(3), .STAT_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .clear_i      (clear_i),
        .clear_busy_o (clear_busy),
        .rd_addr_o    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_wren_o    (rd_wren)
`ifdef REGFILE_ARB_STAT_EN
        ,
        .grant_cnt_o  (grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Structural properties of the grant, sampled just before each edge.
    always @(posedge clk) begin
        if (!rst_i) begin
            checks++;
            assert ($onehot0(req_ready) && ((req_ready & ~req_valid) == 3'b000)
                    && !(clear_busy && (req_ready != 3'b000))) else begin
                errors++;
                $error("FAIL grant_props: observed ready=%b valid=%b busy=%b expected onehot0, subset of valid, zero when busy",
                       req_ready, req_valid, clear_busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset with all requesters valid
        rst_i     = 1'b1;
        clear_i   = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd7, 5'd6, 5'd5};
        req_data  = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_wren", 32'(rd_wren), 32'h0);
            chk("rst_busy", 32'(clear_busy), 32'h0);
        end

        // 2. Single request from req0 to x5
        @(negedge clk);
        rst_i     = 1'b0;
        req_valid = 3'b001;
        #1 chk("single_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        chk("single_addr", 32'(rd_addr), 32'd5);
        chk("single_data", rd_data, 32'hDEAD_BEEF);
        chk("single_wren", 32'(rd_wren), 32'h1);

        // Bring rr_ptr back to 0 via req2 (ptr is 1 now)
        @(negedge clk);
        req_valid = 3'b100;
        #1 chk("req2_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        chk("req2_addr", 32'(rd_addr), 32'd7);

        // 3. Fairness: all valid, rr_ptr=0 -> 0,1,2,0,1,2
        @(negedge clk);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1 chk("fair_ready", 32'(req_ready), 32'(1 << (i % 3)));
            @(posedge clk); #1;
            chk("fair_addr", 32'(rd_addr), 32'(5 + (i % 3)));
            @(negedge clk);
        end

        // 4. Write to x0 from req1
        req_valid       = 3'b010;
        req_addr[9:5]   = 5'd0;
        req_data[63:32] = 32'h0000_1234;
        #1 chk("x0_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        chk("x0_wren", 32'(rd_wren), 32'h0);
`ifdef REGFILE_ARB_STAT_EN
        chk("cnt0", 32'(grant_cnt[15:0]), 32'd3);
        chk("cnt1", 32'(grant_cnt[31:16]), 32'd3);
        chk("cnt2", 32'(grant_cnt[47:32]), 32'd3);
`endif

        // rr_ptr must now be 2: req0 and req2 valid -> req2 wins
        @(negedge clk);
        req_valid = 3'b101;
        #1 chk("ptr_adv_ready", 32'(req_ready), 32'h4);

        // 5. Clear while req2 is valid
        #1 clear_i = 1'b1;
        #1 chk("clr_pulse_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        for (int k = 1; k <= 31; k++) begin
            chk("clr_addr", 32'(rd_addr), 32'(k));
            chk("clr_data", rd_data, 32'h0);
            chk("clr_wren", 32'(rd_wren), 32'h1);
            chk("clr_busy", 32'(clear_busy), 32'h1);
            @(negedge clk);
            clear_i = (k == 15);  // a pulse mid-sequence must be ignored
            #1 chk("clr_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        chk("post_clr_busy", 32'(clear_busy), 32'h0);
        chk("post_clr_wren", 32'(rd_wren), 32'h0);
        chk("post_clr_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        chk("post_clr_addr", 32'(rd_addr), 32'd7);
        chk("post_clr_data", rd_data, 32'h2222_2222);
        chk("post_clr_wr", 32'(rd_wren), 32'h1);
`ifdef REGFILE_ARB_STAT_EN
        chk("cnt2_post", 32'(grant_cnt[47:32]), 32'd4);
`endif

        // 6. Reset in the middle of a clear
        @(negedge clk);
        req_valid = 3'b000;
        clear_i   = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        found   = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(posedge clk); #1;
            if (rd_addr == 5'd10) found = 1'b1;
        end
        chk("reach_x10", 32'(found), 32'h1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(clear_busy), 32'h0);
        chk("midrst_wren", 32'(rd_wren), 32'h0);
        chk("midrst_addr", 32'(rd_addr), 32'h0);
        @(negedge clk);
        rst_i     = 1'b0;
        req_valid = 3'b111;
        #1 chk("midrst_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        chk("midrst_wr_addr", 32'(rd_addr), 32'd5);
        chk("midrst_wr_en", 32'(rd_wren), 32'h1);

        @(negedge clk);
        req_valid = 3'b000;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
